// File: rtl/alu_operand_stage_if.sv
// ---------------------------------------------------------------------------
// alu_operand_stage_if
// Groups the decode-side handshake, instruction fields, forwarding sources,
// flush, and the downstream handshake/operand outputs of alu_operand_stage.
//   master : upstream/downstream environment (drives instruction, forwarding
//            sources, flush, w_out_ready; observes ready/valid/operands)
//   slave  : the operand stage itself
// Parameters: WIDTH (datapath width), SHAMT_W (shift-amount field width).
// ---------------------------------------------------------------------------
interface alu_operand_stage_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               w_in_valid;
    logic               w_in_ready;
    logic               w_mem_op;
    logic               w_imm_op;
    logic               w_shift_op;
    logic [4:0]         w_rs_addr;
    logic [4:0]         w_rt_addr;
    logic [WIDTH-1:0]   w_rs_data;
    logic [WIDTH-1:0]   w_rt_data;
    logic [WIDTH-1:0]   w_imm;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_exm_wen;
    logic               w_exm_load;
    logic [4:0]         w_exm_addr;
    logic [WIDTH-1:0]   w_exm_data;
    logic               w_mwb_wen;
    logic [4:0]         w_mwb_addr;
    logic [WIDTH-1:0]   w_mwb_data;
    logic               w_flush;
    logic               w_out_valid;
    logic               w_out_ready;
    logic [WIDTH-1:0]   w_alu_lhs;
    logic [WIDTH-1:0]   w_alu_rhs;
    logic               w_lhs_sel;
    logic [1:0]         w_rhs_sel;
    logic [1:0]         w_fwd_hit;

    modport master (
        output w_in_valid, w_mem_op, w_imm_op, w_shift_op,
               w_rs_addr, w_rt_addr, w_rs_data, w_rt_data, w_imm, w_shamt,
               w_exm_wen, w_exm_load, w_exm_addr, w_exm_data,
               w_mwb_wen, w_mwb_addr, w_mwb_data, w_flush, w_out_ready,
        input  w_in_ready, w_out_valid, w_alu_lhs, w_alu_rhs,
               w_lhs_sel, w_rhs_sel, w_fwd_hit
    );

    modport slave (
        input  w_in_valid, w_mem_op, w_imm_op, w_shift_op,
               w_rs_addr, w_rt_addr, w_rs_data, w_rt_data, w_imm, w_shamt,
               w_exm_wen, w_exm_load, w_exm_addr, w_exm_data,
               w_mwb_wen, w_mwb_addr, w_mwb_data, w_flush, w_out_ready,
        output w_in_ready, w_out_valid, w_alu_lhs, w_alu_rhs,
               w_lhs_sel, w_rhs_sel, w_fwd_hit
    );
endinterface

// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage
// Selects and forwards the two ALU operands for a decoded instruction and
// registers them behind a valid/ready handshake (latency 1). Detects the
// load-use hazard against the EX/MEM stage and inserts a bubble by holding
// w_in_ready low.
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous active-high reset
//   bus    : alu_operand_stage_if.slave (instruction, forwarding sources,
//            flush, handshakes, registered operands/selections/fwd flags)
//   w_stall_cnt, w_fwd_cnt : 32-bit saturating statistics counters, present
//            only when the macro ALU_OPSTAGE_STATS_EN is defined
// Parameters: WIDTH (datapath width), SHAMT_W (shift field width, < WIDTH).
// ---------------------------------------------------------------------------
module alu_operand_stage #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    alu_operand_stage_if.slave bus
`ifdef ALU_OPSTAGE_STATS_EN
    ,
    output logic [31:0]        w_stall_cnt,
    output logic [31:0]        w_fwd_cnt
`endif
);

    // rhs_sel encodings
    localparam logic [1:0] RHS_RS    = 2'b00;
    localparam logic [1:0] RHS_RT    = 2'b01;
    localparam logic [1:0] RHS_SHAMT = 2'b10;
    localparam logic [1:0] RHS_IMM   = 2'b11;

    // Register 0 is hard-wired, so it never matches a writeback source.
    function automatic logic src_match(input logic       wen,
                                       input logic [4:0] waddr,
                                       input logic [4:0] raddr);
        return wen && (raddr != 5'd0) && (waddr == raddr);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   alu_lhs_q,   alu_lhs_d;
    logic [WIDTH-1:0]   alu_rhs_q,   alu_rhs_d;
    logic               lhs_sel_q,   lhs_sel_d;
    logic [1:0]         rhs_sel_q,   rhs_sel_d;
    logic [1:0]         fwd_hit_q,   fwd_hit_d;

    logic               lhs_sel;
    logic [1:0]         rhs_sel;
    logic               rs_needed, rt_needed;
    logic               exm_rs, exm_rt, mwb_rs, mwb_rt;
    logic [WIDTH-1:0]   rs_val, rt_val;
    logic [1:0]         fwd_hit;
    logic               load_use;
    logic               in_ready;
    logic               transfer;

    // Operand selection, forwarding and hazard detection
    always_comb begin
        lhs_sel = 1'b0;
        rhs_sel = RHS_RT;
        if (bus.w_shift_op) begin
            lhs_sel = 1'b1;
            rhs_sel = bus.w_imm_op ? RHS_SHAMT : RHS_RS;
        end else if (bus.w_mem_op) begin
            rhs_sel = RHS_IMM;
        end else begin
            rhs_sel = bus.w_imm_op ? RHS_IMM : RHS_RT;
        end

        rs_needed = !lhs_sel || (rhs_sel == RHS_RS);
        rt_needed =  lhs_sel || (rhs_sel == RHS_RT);

        exm_rs = src_match(bus.w_exm_wen, bus.w_exm_addr, bus.w_rs_addr);
        exm_rt = src_match(bus.w_exm_wen, bus.w_exm_addr, bus.w_rt_addr);
        mwb_rs = src_match(bus.w_mwb_wen, bus.w_mwb_addr, bus.w_rs_addr);
        mwb_rt = src_match(bus.w_mwb_wen, bus.w_mwb_addr, bus.w_rt_addr);

        // EX/MEM is younger than MEM/WB, so it wins when both match.
        rs_val = exm_rs ? bus.w_exm_data : (mwb_rs ? bus.w_mwb_data : bus.w_rs_data);
        rt_val = exm_rt ? bus.w_exm_data : (mwb_rt ? bus.w_mwb_data : bus.w_rt_data);

        // Only operands actually consumed report a forwarding hit.
        fwd_hit = {rt_needed && (exm_rt || mwb_rt), rs_needed && (exm_rs || mwb_rs)};

        // A load in EX/MEM has no data yet; its consumer must wait a cycle.
        load_use = bus.w_in_valid && bus.w_exm_load &&
                   ((rs_needed && exm_rs) || (rt_needed && exm_rt));

        in_ready = (!out_valid_q || bus.w_out_ready) && !load_use;
        transfer = bus.w_in_valid && in_ready;
    end

    // Output register next-state
    always_comb begin
        out_valid_d = out_valid_q;
        alu_lhs_d   = alu_lhs_q;
        alu_rhs_d   = alu_rhs_q;
        lhs_sel_d   = lhs_sel_q;
        rhs_sel_d   = rhs_sel_q;
        fwd_hit_d   = fwd_hit_q;
        if (bus.w_flush) begin
            // Squash: drop the held result and any same-cycle acceptance.
            out_valid_d = 1'b0;
        end else if (transfer) begin
            out_valid_d = 1'b1;
            alu_lhs_d   = lhs_sel ? rt_val : rs_val;
            unique case (rhs_sel)
                RHS_RS:    alu_rhs_d = rs_val;
                RHS_RT:    alu_rhs_d = rt_val;
                RHS_SHAMT: alu_rhs_d = {{(WIDTH-SHAMT_W){1'b0}}, bus.w_shamt};
                default:   alu_rhs_d = bus.w_imm;
            endcase
            lhs_sel_d   = lhs_sel;
            rhs_sel_d   = rhs_sel;
            fwd_hit_d   = fwd_hit;
        end else if (out_valid_q && bus.w_out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            alu_lhs_q   <= '0;
            alu_rhs_q   <= '0;
            lhs_sel_q   <= 1'b0;
            rhs_sel_q   <= 2'b00;
            fwd_hit_q   <= 2'b00;
        end else begin
            out_valid_q <= out_valid_d;
            alu_lhs_q   <= alu_lhs_d;
            alu_rhs_q   <= alu_rhs_d;
            lhs_sel_q   <= lhs_sel_d;
            rhs_sel_q   <= rhs_sel_d;
            fwd_hit_q   <= fwd_hit_d;
        end
    end

    assign bus.w_in_ready  = in_ready;
    assign bus.w_out_valid = out_valid_q;
    assign bus.w_alu_lhs   = alu_lhs_q;
    assign bus.w_alu_rhs   = alu_rhs_q;
    assign bus.w_lhs_sel   = lhs_sel_q;
    assign bus.w_rhs_sel   = rhs_sel_q;
    assign bus.w_fwd_hit   = fwd_hit_q;

`ifdef ALU_OPSTAGE_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] fwd_cnt_q,   fwd_cnt_d;

    // A flushed acceptance never lands, so it is not counted as forwarded.
    always_comb begin
        stall_cnt_d = load_use ? sat_inc(stall_cnt_q) : stall_cnt_q;
        fwd_cnt_d   = (transfer && !bus.w_flush && (fwd_hit != 2'b00))
                      ? sat_inc(fwd_cnt_q) : fwd_cnt_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign w_stall_cnt = stall_cnt_q;
    assign w_fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_operand_stage
// Directed scenarios followed by randomized traffic, every cycle compared
// against a behavioural model of the operand stage.
// ---------------------------------------------------------------------------
module tb_alu_operand_stage;
    localparam int W  = 32;
    localparam int SW = 5;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    alu_operand_stage_if #(.WIDTH(W), .SHAMT_W(SW)) bus ();

`ifdef ALU_OPSTAGE_STATS_EN
    logic [31:0] w_stall_cnt, w_fwd_cnt;
    alu_operand_stage #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .clock(clock), .reset(reset), .bus(bus),
        .w_stall_cnt(w_stall_cnt), .w_fwd_cnt(w_fwd_cnt));
`else
    alu_operand_stage #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .clock(clock), .reset(reset), .bus(bus));
`endif

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    // Model state (what the registered outputs should currently show)
    logic         m_valid;
    logic [W-1:0] m_lhs, m_rhs;
    logic         m_lsel;
    logic [1:0]   m_rsel, m_hit;
    logic [31:0]  m_stall, m_fcnt;
    // Model predictions for the current input cycle
    logic         p_ready, p_lu, p_xfer;
    logic         n_valid;
    logic [W-1:0] n_lhs, n_rhs;
    logic         n_lsel;
    logic [1:0]   n_rsel, n_hit;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Value the pipeline would deliver for register 'a', and whether it
    // came from an in-flight writer rather than the register file.
    task automatic resolve(input logic [4:0] a, input logic [W-1:0] rf,
                           output logic [W-1:0] v, output logic fwd);
        fwd = 1'b1;
        if (a != 0 && bus.w_exm_wen && bus.w_exm_addr == a)      v = bus.w_exm_data;
        else if (a != 0 && bus.w_mwb_wen && bus.w_mwb_addr == a) v = bus.w_mwb_data;
        else begin v = rf; fwd = 1'b0; end
    endtask

    task automatic model_eval();
        logic use_rs, use_rt, f_rs, f_rt;
        logic [W-1:0] v_rs, v_rt;
        logic [W-1:0] lhs_v, rhs_v;
        logic lsel;
        logic [1:0] rsel;
        resolve(bus.w_rs_addr, bus.w_rs_data, v_rs, f_rs);
        resolve(bus.w_rt_addr, bus.w_rt_data, v_rt, f_rt);
        if (bus.w_shift_op) begin
            lsel = 1; lhs_v = v_rt;
            if (bus.w_imm_op) begin rsel = 2; rhs_v = W'(bus.w_shamt); end
            else              begin rsel = 0; rhs_v = v_rs; end
        end else if (bus.w_mem_op) begin
            lsel = 0; lhs_v = v_rs; rsel = 3; rhs_v = bus.w_imm;
        end else begin
            lsel = 0; lhs_v = v_rs;
            if (bus.w_imm_op) begin rsel = 3; rhs_v = bus.w_imm; end
            else              begin rsel = 1; rhs_v = v_rt; end
        end
        use_rs = (lsel == 0) || (rsel == 0);
        use_rt = (lsel == 1) || (rsel == 1);
        p_lu = bus.w_in_valid && bus.w_exm_wen && bus.w_exm_load &&
               ((use_rs && bus.w_rs_addr != 0 && bus.w_exm_addr == bus.w_rs_addr) ||
                (use_rt && bus.w_rt_addr != 0 && bus.w_exm_addr == bus.w_rt_addr));
        p_ready = (!m_valid || bus.w_out_ready) && !p_lu;
        p_xfer  = bus.w_in_valid && p_ready && !bus.w_flush;
        n_valid = m_valid; n_lhs = m_lhs; n_rhs = m_rhs;
        n_lsel = m_lsel; n_rsel = m_rsel; n_hit = m_hit;
        if (bus.w_flush) n_valid = 0;
        else if (p_xfer) begin
            n_valid = 1; n_lhs = lhs_v; n_rhs = rhs_v; n_lsel = lsel; n_rsel = rsel;
            n_hit = {use_rt && f_rt, use_rs && f_rs};
        end else if (m_valid && bus.w_out_ready) n_valid = 0;
    endtask

    task automatic model_reset();
        m_valid = 0; m_lhs = 0; m_rhs = 0; m_lsel = 0; m_rsel = 0; m_hit = 0;
        m_stall = 0; m_fcnt = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, 64'(bus.w_out_valid), 64'(m_valid));
        check({tag, ".lhs"},       64'(bus.w_alu_lhs),   64'(m_lhs));
        check({tag, ".rhs"},       64'(bus.w_alu_rhs),   64'(m_rhs));
        check({tag, ".lhs_sel"},   64'(bus.w_lhs_sel),   64'(m_lsel));
        check({tag, ".rhs_sel"},   64'(bus.w_rhs_sel),   64'(m_rsel));
        check({tag, ".fwd_hit"},   64'(bus.w_fwd_hit),   64'(m_hit));
`ifdef ALU_OPSTAGE_STATS_EN
        check({tag, ".stall_cnt"}, 64'(w_stall_cnt), 64'(m_stall));
        check({tag, ".fwd_cnt"},   64'(w_fwd_cnt),   64'(m_fcnt));
`endif
    endtask

    // Called at posedge+1 with inputs already applied; ends at next posedge+1.
    task automatic step(input string tag);
        #1;
        model_eval();
        check({tag, ".in_ready"}, 64'(bus.w_in_ready), 64'(p_ready));
        @(posedge clock);
        #1;
        if (p_lu) m_stall = (m_stall == '1) ? m_stall : m_stall + 1;
        if (p_xfer && n_hit != 0) m_fcnt = (m_fcnt == '1) ? m_fcnt : m_fcnt + 1;
        m_valid = n_valid; m_lhs = n_lhs; m_rhs = n_rhs;
        m_lsel = n_lsel; m_rsel = n_rsel; m_hit = n_hit;
        check_outputs(tag);
    endtask

    task automatic idle();
        bus.w_in_valid = 0; bus.w_mem_op = 0; bus.w_imm_op = 0; bus.w_shift_op = 0;
        bus.w_rs_addr = 0; bus.w_rt_addr = 0; bus.w_rs_data = 0; bus.w_rt_data = 0;
        bus.w_imm = 0; bus.w_shamt = 0;
        bus.w_exm_wen = 0; bus.w_exm_load = 0; bus.w_exm_addr = 0; bus.w_exm_data = 0;
        bus.w_mwb_wen = 0; bus.w_mwb_addr = 0; bus.w_mwb_data = 0;
        bus.w_flush = 0; bus.w_out_ready = 1;
    endtask

    logic [W-1:0] held_lhs, held_rhs;

    initial begin
        idle();
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_outputs("reset");
        @(negedge clock);
        reset = 0;
        @(posedge clock); #1;

        // add: plain register operands
        idle();
        bus.w_in_valid = 1; bus.w_rs_addr = 3; bus.w_rs_data = 'h10;
        bus.w_rt_addr = 4; bus.w_rt_data = 'h20;
        step("add");
        check("add.lhs_const", 64'(bus.w_alu_lhs), 64'h10);
        check("add.rhs_const", 64'(bus.w_alu_rhs), 64'h20);
        check("add.rsel_const", 64'(bus.w_rhs_sel), 64'h1);
        check("add.valid_const", 64'(bus.w_out_valid), 64'h1);

        // sll by immediate: rt forwarded from EX/MEM ahead of MEM/WB
        idle();
        bus.w_in_valid = 1; bus.w_shift_op = 1; bus.w_imm_op = 1; bus.w_shamt = 7;
        bus.w_rs_addr = 1; bus.w_rs_data = 'h1111;
        bus.w_rt_addr = 5; bus.w_rt_data = 'h9999;
        bus.w_exm_wen = 1; bus.w_exm_addr = 5; bus.w_exm_data = 'hAB;
        bus.w_mwb_wen = 1; bus.w_mwb_addr = 5; bus.w_mwb_data = 'hCD;
        step("sll");
        check("sll.lhs_const", 64'(bus.w_alu_lhs), 64'hAB);
        check("sll.rhs_const", 64'(bus.w_alu_rhs), 64'h7);
        check("sll.lsel_const", 64'(bus.w_lhs_sel), 64'h1);
        check("sll.rsel_const", 64'(bus.w_rhs_sel), 64'h2);
        check("sll.hit_const", 64'(bus.w_fwd_hit), 64'h2);

        // addi from r0: writer to r0 must be ignored
        idle();
        bus.w_in_valid = 1; bus.w_imm_op = 1; bus.w_imm = 'h44;
        bus.w_rs_addr = 0; bus.w_rs_data = 'h1234;
        bus.w_exm_wen = 1; bus.w_exm_addr = 0; bus.w_exm_data = 'hFF;
        step("addi_r0");
        check("addi_r0.lhs_const", 64'(bus.w_alu_lhs), 64'h1234);
        check("addi_r0.hit_const", 64'(bus.w_fwd_hit), 64'h0);

        // lw after load into its base register: one bubble, then MEM/WB forward
        idle();
        bus.w_in_valid = 1; bus.w_mem_op = 1; bus.w_imm = 'h8;
        bus.w_rs_addr = 2; bus.w_rs_data = 'h77;
        bus.w_exm_wen = 1; bus.w_exm_load = 1; bus.w_exm_addr = 2; bus.w_exm_data = 'hEE;
        #1;
        check("lw.bubble_ready_const", 64'(bus.w_in_ready), 64'h0);
        step("lw_bubble");
        bus.w_exm_wen = 0; bus.w_exm_load = 0;
        bus.w_mwb_wen = 1; bus.w_mwb_addr = 2; bus.w_mwb_data = 'h55;
        step("lw");
        check("lw.lhs_const", 64'(bus.w_alu_lhs), 64'h55);
        check("lw.rhs_const", 64'(bus.w_alu_rhs), 64'h8);
`ifdef ALU_OPSTAGE_STATS_EN
        check("lw.stall_const", 64'(w_stall_cnt), 64'h1);
`endif

        // backpressure hold for 3 cycles, then flush
        held_lhs = bus.w_alu_lhs; held_rhs = bus.w_alu_rhs;
        idle();
        bus.w_out_ready = 0; bus.w_in_valid = 1; bus.w_rs_addr = 6; bus.w_rs_data = 'hDEAD;
        bus.w_rt_addr = 7; bus.w_rt_data = 'hBEEF;
        for (int i = 0; i < 3; i++) begin
            step("hold");
            check("hold.lhs_const", 64'(bus.w_alu_lhs), 64'(held_lhs));
            check("hold.rhs_const", 64'(bus.w_alu_rhs), 64'(held_rhs));
            check("hold.valid_const", 64'(bus.w_out_valid), 64'h1);
        end
        bus.w_flush = 1;
        step("flush");
        check("flush.valid_const", 64'(bus.w_out_valid), 64'h0);

        // async reset while holding a valid result
        idle();
        bus.w_in_valid = 1; bus.w_rs_addr = 1; bus.w_rs_data = 'h3; bus.w_rt_data = 'h4;
        step("pre_reset");
        idle();
        bus.w_out_ready = 0;
        #2;
        reset = 1;
        #1;
        model_reset();
        check_outputs("async_reset");
        check("async_reset.valid_const", 64'(bus.w_out_valid), 64'h0);
        @(negedge clock);
        reset = 0;
        @(posedge clock); #1;

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            bus.w_in_valid  = ($urandom_range(0, 3) != 0);
            bus.w_mem_op    = $urandom_range(0, 1);
            bus.w_imm_op    = $urandom_range(0, 1);
            bus.w_shift_op  = ($urandom_range(0, 2) == 0);
            bus.w_rs_addr   = 5'($urandom_range(0, 3));
            bus.w_rt_addr   = 5'($urandom_range(0, 3));
            bus.w_rs_data   = $urandom;
            bus.w_rt_data   = $urandom;
            bus.w_imm       = $urandom;
            bus.w_shamt     = 5'($urandom);
            bus.w_exm_wen   = $urandom_range(0, 1);
            bus.w_exm_load  = ($urandom_range(0, 2) == 0);
            bus.w_exm_addr  = 5'($urandom_range(0, 3));
            bus.w_exm_data  = $urandom;
            bus.w_mwb_wen   = $urandom_range(0, 1);
            bus.w_mwb_addr  = 5'($urandom_range(0, 3));
            bus.w_mwb_data  = $urandom;
            bus.w_flush     = ($urandom_range(0, 9) == 0);
            bus.w_out_ready = ($urandom_range(0, 3) != 0);
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameter WIDTH, default 32, datapath width of operands, forwarding data and immediate.
REQ-002 Parameter SHAMT_W, default 5, shift-amount field width; SHALL be less than WIDTH.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 w_in_valid  input  1  decoded instruction presented; w_in_ready  output  1  stage accepts this cycle.
REQ-006 w_mem_op, w_imm_op, w_shift_op  input  1 each  instruction class flags.
REQ-007 w_rs_addr, w_rt_addr  input  5 each; w_rs_data, w_rt_data  input  WIDTH each  register-file read values.
REQ-008 w_imm  input  WIDTH  extended immediate; w_shamt  input  SHAMT_W  shift amount.
REQ-009 w_exm_wen, w_exm_load  input  1 each; w_exm_addr  input  5; w_exm_data  input  WIDTH  EX/MEM writeback source.
REQ-010 w_mwb_wen  input  1; w_mwb_addr  input  5; w_mwb_data  input  WIDTH  MEM/WB writeback source.
REQ-011 w_flush  input  1  synchronous squash of the stage.
REQ-012 w_out_valid  output  1; w_out_ready  input  1  downstream handshake.
REQ-013 w_alu_lhs, w_alu_rhs  output  WIDTH each  registered ALU operands.
REQ-014 w_lhs_sel  output  1; w_rhs_sel  output  2  registered selections; w_fwd_hit  output  2  registered {rt,rs} forwarded flags.

Function
REQ-015 Selection SHALL be: shift -> lhs=rt, rhs=shamt if imm else rs; else mem -> lhs=rs, rhs=imm; else lhs=rs, rhs=imm if imm else rt.
REQ-016 Encodings SHALL be lhs_sel 0=rs,1=rt; rhs_sel 00=rs, 01=rt, 10=shamt zero-extended to WIDTH, 11=imm.
REQ-017 rs is needed when lhs_sel=0 or rhs_sel=00; rt is needed when lhs_sel=1 or rhs_sel=01.
REQ-018 Each source value SHALL be forwarded: EX/MEM when exm_wen and exm_addr matches, else MEM/WB when mwb_wen and mwb_addr matches, else register-file data; EX/MEM has priority.
REQ-019 Address 0 SHALL never match a forwarding source; operand is register-file data.
REQ-020 Load-use hazard: in_valid, needed source address nonzero, exm_wen, exm_load and exm_addr match -> w_in_ready SHALL be 0 that cycle (bubble).
REQ-021 w_in_ready SHALL equal (!w_out_valid or w_out_ready) and no load-use hazard.
REQ-022 Transfer occurs when w_in_valid and w_in_ready; outputs SHALL update on the next edge (latency 1) and w_out_valid SHALL be 1.
REQ-023 When out_valid and !out_ready, all outputs SHALL hold stable.
REQ-024 When out_valid, out_ready and no transfer, w_out_valid SHALL go 0; operand outputs hold.
REQ-025 w_flush SHALL clear w_out_valid next edge and drop any same-cycle input transfer; flush overrides load and hold.
REQ-026 w_fwd_hit[0]/[1] SHALL be 1 when the captured rs/rt value came from a forwarding source.

Reset
REQ-027 On reset: w_out_valid=0, w_alu_lhs=0, w_alu_rhs=0, w_lhs_sel=0, w_rhs_sel=00, w_fwd_hit=00, immediately and asynchronously.
REQ-028 Reset mid-transfer SHALL discard the pending instruction; first acceptance possible on first edge after release.

Configuration
REQ-029 Macro ALU_OPSTAGE_STATS_EN: when defined, add outputs w_stall_cnt and w_fwd_cnt (32 bits each), reset to 0, incrementing per load-use bubble cycle and per transfer with any fwd hit respectively, saturating at all-ones.
REQ-030 Without ALU_OPSTAGE_STATS_EN, those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-031 add rs=3(0x10), rt=4(0x20), no forwarding -> next cycle lhs=0x10, rhs=0x20, rhs_sel=01, out_valid=1.
REQ-032 sll imm shamt=7, rt=5, exm_wen addr=5 data=0xAB, mwb addr=5 data=0xCD -> lhs=0xAB, rhs=0x7, lhs_sel=1, rhs_sel=10, fwd_hit=10.
REQ-033 addi rs=0 with exm_wen addr=0 data=0xFF -> lhs=rs-file value, fwd_hit=00.
REQ-034 lw rs=2, exm_load addr=2 -> in_ready=0 one cycle; next cycle exm clear, mwb addr=2 data=0x55 -> lhs=0x55, rhs=imm; stall_cnt=1 with macro.
REQ-035 out_ready=0 for 3 cycles with out_valid=1 -> outputs stable, in_ready=0; then flush with in_valid=1 -> out_valid=0 next cycle.
REQ-036 Assert reset while out_valid=1 -> all outputs zero immediately, out_valid=0.
